// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// sampled row lines and reports each accepted press once as a key code plus strobe.
module module_keypad_scanner #(
    parameter int SCAN_TICKS     = 27000,
    parameter int DEBOUNCE_TICKS = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    // The high sample that leaves HELD is the first of the release run.
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(DEBOUNCE_TICKS - 2);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [1:0]       col_idx, col_n;
    logic [1:0]       row_idx, row_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       code_n;
    logic             valid_n;
    logic             held_n;

    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic             row_any;
    logic [1:0]       row_hit;
    logic             row_sel_high;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = 4'd10;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = 4'd11;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = 4'd12;
            4'hC:    code = 4'd14;
            4'hD:    code = 4'd0;
            4'hE:    code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Rows idle high through pull-ups, so the synchronizer resets to all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_s    <= 4'b1111;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its source, which is what builds the two-stage chain.
            row_meta <= row;
            row_s    <= row_meta;
        end
    end

    // Lowest-index low row wins when several keys share the scanned column.
    always_comb begin
        row_any = ~&row_s;
        row_hit = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s[i]) begin
                row_hit = 2'(i);
            end
        end
    end

    assign row_sel_high = row_s[row_idx];
    assign cnt_inc      = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement can infer a latch.
        state_n = state;
        col_n   = col_idx;
        row_n   = row_idx;
        cnt_n   = cnt;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;

        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_n = '0;
                    if (row_any) begin
                        row_n   = row_hit;
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col_idx + 2'd1;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            DEBOUNCE: begin
                if (row_sel_high) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    code_n  = key_lookup(row_idx, col_idx);
                    valid_n = 1'b1;
                    held_n  = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            HELD: begin
                if (row_sel_high) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end
            end

            RELEASE: begin
                if (!row_sel_high) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == REL_LAST) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                    held_n  = 1'b0;
                    col_n   = col_idx + 2'd1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            default: begin
                state_n = SCAN;
                cnt_n   = '0;
            end
        endcase
    end

    // NOTE: every state flop here has an explicit reset value; none of this is
    // memory, so nothing is left to power-up state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            cnt       <= '0;
            column    <= 4'b1110;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_n;
            row_idx   <= row_n;
            cnt       <= cnt_n;
            column    <= ~(4'b0001 << col_n);
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Bench for module_keypad_scanner: a keypad model gates pressed keys by the driven
// column; expected key codes go into a queue and are popped on each key_valid.
module tb_module_keypad_scanner;

    localparam int SCAN_TICKS     = 4;
    localparam int DEBOUNCE_TICKS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] column;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] keys = '0;   // keys[r][c] = 1 while that key is pressed

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    logic [3:0] exp_q[$];

    module_keypad_scanner #(
        .SCAN_TICKS    (SCAN_TICKS),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .column   (column),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r][c] && !column[c]) row[r] = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every key_valid must match the next queued code.
    always @(negedge clk) begin
        logic [3:0] exp_code;
        checks++;
        if ($countones(~column) != 1) begin
            errors++;
            $display("FAIL column_onehot column=%b required exactly one low bit", column);
        end
        if (key_valid === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse key_code=%0d required no pulse", key_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (key_code !== exp_code) begin
                    errors++;
                    $display("FAIL pulse_code key_code=%0d required %0d", key_code, exp_code);
                end
            end
            checks++;
            if (key_held !== 1'b1) begin
                errors++;
                $display("FAIL held_with_pulse key_held=%b required 1", key_held);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_pulse(input int target, input string name);
        int n = 0;
        while (pulses < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (pulses < target) begin
            errors++;
            $display("FAIL %s_timeout pulses=%0d required %0d", name, pulses, target);
        end
    endtask

    task automatic wait_column(input logic [3:0] target, input string name);
        int n = 0;
        while (column !== target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (column !== target) begin
            errors++;
            $display("FAIL %s_column_timeout column=%b required %b", name, column, target);
        end
    endtask

    // Called just after a rising edge: releases all keys and measures cycles to key_held=0.
    task automatic release_and_time(input string name, input logic [3:0] frozen_col,
                                    input logic [3:0] next_col);
        int         n    = 0;
        logic       done = 1'b0;
        logic [3:0] prev_col;
        prev_col = column;
        keys = '0;
        while (!done && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (key_held === 1'b0) done = 1'b1;
            else prev_col = column;
        end
        checks++;
        if (n != 2 + DEBOUNCE_TICKS) begin
            errors++;
            $display("FAIL %s_release_latency cycles=%0d required %0d", name, n, 2 + DEBOUNCE_TICKS);
        end
        checks++;
        if (prev_col !== frozen_col) begin
            errors++;
            $display("FAIL %s_frozen_column column=%b required %b", name, prev_col, frozen_col);
        end
        checks++;
        if (column !== next_col) begin
            errors++;
            $display("FAIL %s_next_column column=%b required %b", name, column, next_col);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst  = 1'b1;
        keys = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (column !== 4'b1110) begin
            errors++;
            $display("FAIL reset_column column=%b required 1110", column);
        end
        checks++;
        if ({key_code, key_valid, key_held} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs code=%0d valid=%b held=%b required 0 0 0",
                     key_code, key_valid, key_held);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / SCAN_TICKS) % 4));
            checks++;
            if (column !== exp_col) begin
                errors++;
                $display("FAIL idle_scan step=%0d column=%b required %b", i, column, exp_col);
            end
        end
        checks++;
        if (pulses != 0 || key_code !== 4'd0) begin
            errors++;
            $display("FAIL idle_no_key pulses=%0d code=%0d required 0 0", pulses, key_code);
        end
    endtask

    task automatic test_press_5();
        int   base = pulses;
        logic held_ok = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(4'd5);
        keys[1][1] = 1'b1;
        wait_pulse(base + 1, "press5");
        repeat (40) begin
            @(negedge clk);
            if (key_held !== 1'b1) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL press5_held key_held dropped while pressed, required 1");
        end
        @(posedge clk);
        #1;
        release_and_time("press5", 4'b1101, 4'b1011);
        checks++;
        if (key_code !== 4'd5 || pulses != base + 1) begin
            errors++;
            $display("FAIL press5_after code=%0d pulses=%0d required 5 %0d",
                     key_code, pulses, base + 1);
        end
    endtask

    task automatic test_bounce_a();
        int base;
        wait_column(4'b0111, "bounceA");
        base = pulses;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            keys[0][3] = (k % 2 == 0);
            repeat (2) @(posedge clk);
        end
        checks++;
        if (pulses != base) begin
            errors++;
            $display("FAIL bounceA_no_pulse pulses=%0d required %0d", pulses, base);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(4'd10);
        keys[0][3] = 1'b1;
        wait_pulse(base + 1, "bounceA");
        @(posedge clk);
        #1;
        release_and_time("bounceA", 4'b0111, 4'b1110);
    endtask

    task automatic test_release_bounce_b();
        int   base = pulses;
        logic held_ok = 1'b1;
        wait_column(4'b0111, "relB");
        exp_q.push_back(4'd11);
        keys[1][3] = 1'b1;
        wait_pulse(base + 1, "relB");
        @(posedge clk);
        #1;
        keys = '0;
        repeat (3) begin
            @(negedge clk);
            if (key_held !== 1'b1) held_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        keys[1][3] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (key_held !== 1'b1) held_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        release_and_time("relB", 4'b0111, 4'b1110);
        checks++;
        if (!held_ok || pulses != base + 1) begin
            errors++;
            $display("FAIL relB_glitch held_ok=%b pulses=%0d required 1 %0d",
                     held_ok, pulses, base + 1);
        end
    endtask

    task automatic test_two_keys();
        int base = pulses;
        @(posedge clk);
        #1;
        exp_q.push_back(4'd1);
        keys[0][0] = 1'b1;
        keys[2][0] = 1'b1;
        wait_pulse(base + 1, "two_keys");
        @(posedge clk);
        #1;
        release_and_time("two_keys", 4'b1110, 4'b1101);
        exp_q.push_back(4'd0);
        keys[3][1] = 1'b1;
        wait_pulse(base + 2, "key0");
        checks++;
        if (key_code !== 4'd0) begin
            errors++;
            $display("FAIL key0_code key_code=%0d required 0", key_code);
        end
        @(posedge clk);
        #1;
        release_and_time("key0", 4'b1101, 4'b1011);
    endtask

    task automatic test_reset_held();
        int base = pulses;
        @(posedge clk);
        #1;
        exp_q.push_back(4'd15);
        keys[3][2] = 1'b1;
        wait_pulse(base + 1, "hash");
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (key_held !== 1'b1 || key_code !== 4'd15) begin
            errors++;
            $display("FAIL hash_held held=%b code=%0d required 1 15", key_held, key_code);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (column !== 4'b1110) begin
            errors++;
            $display("FAIL async_reset_column column=%b required 1110", column);
        end
        checks++;
        if ({key_code, key_valid, key_held} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_outputs code=%0d valid=%b held=%b required 0 0 0",
                     key_code, key_valid, key_held);
        end
        exp_q.push_back(4'd15);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_pulse(base + 2, "hash_redetect");
        checks++;
        if (key_code !== 4'd15 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL hash_redetect code=%0d held=%b required 15 1", key_code, key_held);
        end
        @(posedge clk);
        #1;
        release_and_time("hash", 4'b1011, 4'b0111);
    endtask

    initial begin
        test_reset();
        test_press_5();
        test_bounce_a();
        test_release_bounce_b();
        test_two_keys();
        test_reset_held();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
